// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer between two load/store masters and the shared
// data-memory/UART register port; UART-register writes wait out uart_busy.
module data_mem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned UART_BIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wd,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wd,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd,
    input  logic              uart_busy,
    output logic              arb_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_UART,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;     // 1 = m1 was granted last
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              uart_sel;

    assign uart_sel = addr_q[UART_BIT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    // Under contention the master not granted last wins.
                    owner_d = (m0_req && m1_req) ? ~last_q : m1_req;
                    last_d  = owner_d;
                    we_d    = owner_d ? m1_we   : m0_we;
                    addr_d  = owner_d ? m1_addr : m0_addr;
                    wd_d    = owner_d ? m1_wd   : m0_wd;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!we_q) begin
                    rdata_d = mem_rd;
                    state_d = S_RESP;
                end else if (uart_sel && uart_busy) begin
                    state_d = S_WAIT_UART;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WAIT_UART: begin
                if (!uart_busy) state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign m0_gnt    = (state_q == S_ISSUE) && !owner_q;
    assign m1_gnt    = (state_q == S_ISSUE) &&  owner_q;
    assign m0_rvalid = (state_q == S_RESP)  && !owner_q;
    assign m1_rvalid = (state_q == S_RESP)  &&  owner_q;
    assign arb_busy  = (state_q != S_IDLE);
    assign mem_we    = we_q && (((state_q == S_ISSUE) && !(uart_sel && uart_busy)) ||
                                ((state_q == S_WAIT_UART) && !uart_busy));
    assign mem_a     = addr_q;
    assign mem_wd    = wd_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized self-checking bench for data_mem_arbiter against a transaction-level
// model: round-robin winner choice plus per-transaction timing from the command type.
module tb_data_mem_arbiter;

    localparam int UB = 8;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wd;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wd;
    logic [31:0] rdata, mem_a, mem_wd, mem_rd;
    logic        mem_we, uart_busy, arb_busy;
    logic [5:0]  ctl;

    logic        force_en = 1'b0;
    logic [31:0] force_val = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int we_cnt = 0;
    int gnt_cyc = 0;

    cmd_t        pend[2];
    bit          has[2];
    int          last_w;
    logic [31:0] rdata_m;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .UART_BIT(UB)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .rdata(rdata), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we),
        .mem_rd(mem_rd), .uart_busy(uart_busy), .arb_busy(arb_busy)
    );

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rd_value(input logic [31:0] a);
        return force_en ? force_val : hash(a);
    endfunction

    assign mem_rd = rd_value(mem_a);
    assign ctl    = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, arb_busy};

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_we === 1'b1) we_cnt <= we_cnt + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.we       = 1'($urandom_range(0, 1));
        c.addr     = $urandom;
        c.addr[UB] = 1'($urandom_range(0, 1));
        c.wd       = $urandom;
        return c;
    endfunction

    // Idle masters get scrambled command lines so only the latched copy can be used.
    task automatic drive_req();
        for (int i = 0; i < 2; i++) if (!has[i]) pend[i] = rand_cmd();
        m0_req = has[0]; m0_we = pend[0].we; m0_addr = pend[0].addr; m0_wd = pend[0].wd;
        m1_req = has[1]; m1_we = pend[1].we; m1_addr = pend[1].addr; m1_wd = pend[1].wd;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        has[0] = 0; has[1] = 0;
        drive_req();
        uart_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        last_w  = 1;
        rdata_m = '0;
        #2 check_eq("reset_ctl", {58'd0, ctl}, 64'd0);
    endtask

    // One transaction of the model's winner. L = cycles uart_busy is held high starting
    // at the issue cycle; only a UART-register write stalls on it.
    task automatic serve(input int L, input bit rearm, input int late_m, input int late_c);
        int   w, stall, wc, rv, w0;
        cmd_t c;
        bit   uw;
        logic [5:0] exp;
        if (!has[0] && !has[1]) return;
        drive_req();
        w = (has[0] && has[1]) ? ((last_w == 1) ? 0 : 1) : (has[0] ? 0 : 1);
        last_w = w;
        c = pend[w];
        has[w] = 0;
        uw    = c.we && c.addr[UB];
        stall = uw ? L : 0;
        wc    = c.we ? stall + 1 : -1;
        rv    = stall + 2;
        w0    = we_cnt;
        for (int cy = 1; cy <= rv + 1; cy++) begin
            @(posedge clk);
            #1;
            if (cy == 1) begin
                gnt_cyc = cyc;
                if (rearm) begin
                    pend[w]    = rand_cmd();
                    pend[w].we = ~c.we;
                    has[w]     = 1;
                end
                if (!c.we) rdata_m = rd_value(c.addr);
                drive_req();
            end
            if (late_m >= 0 && late_m != w && cy == late_c && !has[late_m]) begin
                pend[late_m] = rand_cmd();
                has[late_m]  = 1;
                drive_req();
            end
            uart_busy = uw ? (cy <= L) : ((L > 0) ? 1'b1 : 1'($urandom_range(0, 1)));
            #2;
            exp = {w == 0 && cy == 1, w == 1 && cy == 1, w == 0 && cy == rv,
                   w == 1 && cy == rv, cy == wc, cy <= rv};
            check_eq("ctl", {58'd0, ctl}, {58'd0, exp});
            if (cy == 1 || cy == wc) begin
                check_eq("mem_a", {32'd0, mem_a}, {32'd0, c.addr});
                check_eq("mem_wd", {32'd0, mem_wd}, {32'd0, c.wd});
            end
            if (cy == rv) check_eq("rdata", {32'd0, rdata}, {32'd0, rdata_m});
        end
        check_eq("we_pulses", we_cnt - w0, c.we ? 1 : 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 4 && (has[0] || has[1]); k++) serve(0, 0, -1, 0);
    endtask

    initial begin
        int prev, w0;
        reset = 1'b0;
        uart_busy = 1'b0;
        has[0] = 0; has[1] = 0;
        drive_req();
        last_w = 1;
        rdata_m = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #2;
        check_eq("reset_ctl", {58'd0, ctl}, 64'd0);
        check_eq("reset_rdata", {32'd0, rdata}, 64'd0);
        check_eq("reset_mem_a", {32'd0, mem_a}, 64'd0);
        check_eq("reset_mem_wd", {32'd0, mem_wd}, 64'd0);

        // Reset arriving in the middle of a stalled UART write.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h100; m0_wd = 32'h41;
        uart_busy = 1'b1;
        @(posedge clk); #1 m0_req = 1'b0;
        #2 check_eq("stall_issue", {58'd0, ctl}, 64'b100001);
        @(posedge clk); #3 check_eq("stall_wait", {58'd0, ctl}, 64'b000001);
        w0 = we_cnt;
        #1 reset = 1'b0;
        #1 check_eq("async_ctl", {58'd0, ctl}, 64'd0);
        check_eq("async_mem_a", {32'd0, mem_a}, 64'd0);
        @(posedge clk); #1 uart_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_eq("no_write_after_rst", we_cnt - w0, 0);
        check_eq("idle_ctl", {58'd0, ctl}, 64'd0);
        last_w = 1;
        rdata_m = '0;

        // Single m0 read with a fixed memory word.
        force_en = 1'b1; force_val = 32'hDEAD_BEEF;
        pend[0] = '{we: 1'b0, addr: 32'h05, wd: 32'h0}; has[0] = 1;
        serve(0, 0, -1, 0);
        check_eq("deadbeef", {32'd0, rdata}, 64'hDEAD_BEEF);
        force_en = 1'b0;

        // Single m1 memory write; rdata must keep the previous read value.
        pend[1] = '{we: 1'b1, addr: 32'h10, wd: 32'h1234_5678}; has[1] = 1;
        serve(0, 0, -1, 0);
        check_eq("rdata_kept", {32'd0, rdata}, 64'hDEAD_BEEF);

        // Continuous contention from a fresh reset.
        apply_reset();
        pend[0] = rand_cmd(); pend[1] = rand_cmd(); has[0] = 1; has[1] = 1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            serve(0, 1, -1, 0);
            check_eq("rr_order", last_w, i % 2);
            if (i > 0) check_eq("rr_gap", gnt_cyc - prev, 3);
            prev = gnt_cyc;
        end
        drain();

        // UART write stalled 5 cycles; m1 asks during the stall.
        pend[0] = '{we: 1'b1, addr: 32'h100, wd: 32'h41}; has[0] = 1;
        serve(5, 0, 1, 3);
        check_eq("stall_m1_pending", has[1], 1);
        serve(0, 0, -1, 0);
        check_eq("stall_next_winner", last_w, 1);

        // UART read while transmitter busy: no stall.
        pend[1] = '{we: 1'b0, addr: 32'h100, wd: 32'h0}; has[1] = 1;
        serve(5, 0, -1, 0);
        check_eq("uart_read", {32'd0, rdata}, {32'd0, hash(32'h100)});

        // m0 alone, back to back, alternating read/write.
        pend[0] = rand_cmd(); pend[0].we = 1'b0; has[0] = 1;
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            serve(0, 1, -1, 0);
            check_eq("b2b_owner", last_w, 0);
            if (i > 0) check_eq("b2b_gap", gnt_cyc - prev, 3);
            prev = gnt_cyc;
        end
        drain();

        // Random traffic.
        for (int r = 0; r < 80; r++) begin
            for (int i = 0; i < 2; i++) begin
                if (!has[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = rand_cmd();
                    has[i]  = 1;
                end
            end
            if (!has[0] && !has[1]) begin
                int m;
                m = int'($urandom_range(0, 1));
                pend[m] = rand_cmd();
                has[m]  = 1;
            end
            serve(int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, 1)), int'($urandom_range(1, 2)));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester, round-robin arbiter and sequencer for the shared data-memory/UART address space. It sits in front of the combined data-memory/UART-register block: it accepts load/store commands from the core port (m0) and a secondary master such as a loader or DMA (m1), and issues them one at a time on the single memory port. It stalls UART-register writes (addr bit UART_BIT = 1) while the serial transmitter reports busy. It returns read data and a per-master completion pulse.

## Interface
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width
- UART_BIT, 8, address bit that selects the UART register (1) vs data memory (0)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1  command request; held high until the matching gnt
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  ADDR_W  byte/word address as used by the memory block
- m0_wd, m1_wd  in  DATA_W  write data
- m0_gnt, m1_gnt  out  1  one-cycle pulse: command accepted and latched
- m0_rvalid, m1_rvalid  out  1  one-cycle pulse: transaction complete; rdata valid for reads
- rdata  out  DATA_W  read data of the last completed read; shared by both masters
- mem_a  out  ADDR_W  address to the memory/UART block
- mem_wd  out  DATA_W  write data to the memory/UART block
- mem_we  out  1  write enable to the memory/UART block
- mem_rd  in  DATA_W  combinational read data from the memory/UART block
- uart_busy  in  1  transmitter busy; UART-register writes are held while high
- arb_busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, ISSUE, WAIT_UART, RESP.
- IDLE: if any req is high at a clock edge, select a winner, latch its we/addr/wd into the command register, record it in last_grant, and go to ISSUE.
- Round-robin selection: with both requests high, the master not in last_grant wins. With one request high, that master wins. last_grant resets to m1, so m0 wins the first contention.
- ISSUE: the winner's gnt is high for this cycle only. mem_a and mem_wd are driven from the latched command.
  - Read: capture mem_rd into rdata at the end of the cycle, then go to RESP.
  - Write to memory (addr[UART_BIT] = 0): mem_we = 1, then go to RESP.
  - Write to UART with uart_busy = 0: mem_we = 1, then go to RESP.
  - Write to UART with uart_busy = 1: mem_we = 0, then go to WAIT_UART.
- WAIT_UART: mem_a and mem_wd are held. mem_we = 1 in the first cycle in which uart_busy = 0, then go to RESP. There is no timeout. The other master's req stays pending.
- RESP: the owner's rvalid is high for one cycle, then go to IDLE. rdata is unchanged for writes.
- UART-register reads never wait on uart_busy.
- mem_we is high for exactly one cycle per write transaction and never for reads.
- A req still high in IDLE after rvalid starts a new transaction. Requesters drop req in the cycle after gnt if they want only one transaction.

## Timing
- Reset (reset = 0, asynchronous):
  - state = IDLE, last_grant = m1.
  - Outputs cleared: gnt*, rvalid*, mem_we, arb_busy, rdata, mem_a, mem_wd.
  - An in-flight command is dropped and no write is issued.
- Latency, with req sampled at edge 0:
  - gnt during cycle 1 (ISSUE).
  - rvalid during cycle 2 (RESP).
  - Next grant at the earliest during cycle 4.
- Peak throughput: one transaction per 3 cycles.
- UART write while busy: total latency is 3 cycles plus the number of cycles uart_busy stays high after ISSUE.
- gnt, rvalid, mem_we and arb_busy are decoded from registered state and the latched command. No combinational path exists from req to gnt.
- uart_busy reaches mem_we combinationally in ISSUE and WAIT_UART.

## Test plan
- Reset and idle: reset low mid-WAIT_UART, then high.
  - Required: all outputs 0, state IDLE, no mem_we pulse.
  - Then a single m0 read of addr 0x05 with mem_rd = 0xDEADBEEF: m0_gnt at cycle 1, m0_rvalid at cycle 2, rdata = 0xDEADBEEF.
- Single write: m1 writes 0x12345678 to addr 0x10.
  - Required: mem_we pulses exactly once in ISSUE with mem_a = 0x10 and mem_wd = 0x12345678.
  - m1_rvalid follows one cycle later; rdata is unchanged.
- Contention: m0_req and m1_req held high continuously for 4 transactions.
  - Required: grant order m0, m1, m0, m1, with gnt pulses 3 cycles apart.
- UART stall: m0 writes 0x41 to addr 0x100 with uart_busy high for 5 cycles after ISSUE.
  - Required: mem_we = 0 during the stall, then exactly one pulse with mem_a = 0x100.
  - m0_rvalid follows one cycle later.
  - An m1 request raised during the stall is granted only after m0_rvalid.
- UART read while busy: m1 reads addr 0x100 with uart_busy = 1.
  - Required: no stall; m1_rvalid at cycle 2 with rdata = mem_rd.
- Back-to-back from the same master: m0_req held high, alternating read and write, with no m1 request.
  - Required: m0 is granted every 3 cycles and m1_gnt stays 0.
